// File: rtl/sprite_fetch_sequencer_pkg.sv
// Shared types and helpers for the sprite (OBJ) fetch path: fetch FSM states,
// attribute bit positions and the tile-row VRAM address function.
package obj_pkg;

  localparam int ADDR_W     = 13;
  localparam int FLAG_XFLIP = 5;
  localparam int FLAG_YFLIP = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_CAP_LO,
    ST_REQ_HI,
    ST_CAP_HI,
    ST_LOAD
  } fetch_state_t;

  // Each tile is 16 bytes (8 rows x 2 planes). For 8x16 sprites the 4-bit row
  // spills into tile bit 0, which is why that bit is forced low.
  function automatic logic [ADDR_W-1:0] obj_row_addr(
    input logic [7:0] tile,
    input logic [3:0] line,
    input logic       size16,
    input logic       yflip,
    input logic       plane
  );
    logic [3:0] row;
    logic [7:0] tile_eff;
    row      = size16 ? line : {1'b0, line[2:0]};
    if (yflip) begin
      row = size16 ? ~row : {1'b0, ~row[2:0]};
    end
    tile_eff     = size16 ? {tile[7:1], 1'b0} : tile;
    obj_row_addr = ADDR_W'({tile_eff, 4'b0000}) + ADDR_W'({row, plane});
  endfunction

endpackage

// File: rtl/obj_row_addr_gen.sv
// Combinational tile-row address generator, shared by the fetch sequencer and
// the OAM-scan debug path.
module obj_row_addr_gen
  import obj_pkg::*;
(
  input  logic [7:0]        tile_i,
  input  logic [3:0]        line_i,
  input  logic              size16_i,
  input  logic              yflip_i,
  input  logic              plane_i,
  output logic [ADDR_W-1:0] addr_o
);

  assign addr_o = obj_row_addr(tile_i, line_i, size16_i, yflip_i, plane_i);

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// Sprite row fetcher: reads low/high plane bytes from VRAM, strobes them onto
// the md bus for the pixel shifter and issues the per-slot parallel-load mask.
module sprite_fetch_sequencer
  import obj_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              fetch_req_i,
  input  logic              fetch_abort_i,
  input  logic [7:0]        spr_tile_i,
  input  logic [7:0]        spr_attr_i,
  input  logic [3:0]        spr_line_i,
  input  logic              obj_size16_i,
  input  logic [7:0]        pipe_occ_i,
  output logic              vram_req_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  input  logic              vram_ack_i,
  input  logic [7:0]        vram_data_i,
  output logic [7:0]        md_o,
  output logic              xono_o,
  output logic              latch_lo_o,
  output logic              latch_hi_o,
  output logic [7:0]        load_mask_o,
  output logic              busy_o,
  output logic              fetch_done_o
);

  fetch_state_t      state_q, state_d;
  logic [7:0]        tile_q, tile_d;
  logic [3:0]        line_q, line_d;
  logic              size16_q, size16_d;
  logic              yflip_q, yflip_d;
  logic              xono_q, xono_d;
  logic [7:0]        md_q, md_d;
  logic              plane;
  logic [ADDR_W-1:0] row_addr;

  assign plane = (state_q == ST_REQ_HI);

  obj_row_addr_gen u_addr_gen (
    .tile_i   (tile_q),
    .line_i   (line_q),
    .size16_i (size16_q),
    .yflip_i  (yflip_q),
    .plane_i  (plane),
    .addr_o   (row_addr)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      tile_q   <= '0;
      line_q   <= '0;
      size16_q <= 1'b0;
      yflip_q  <= 1'b0;
      xono_q   <= 1'b0;
      md_q     <= '0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      line_q   <= line_d;
      size16_q <= size16_d;
      yflip_q  <= yflip_d;
      xono_q   <= xono_d;
      md_q     <= md_d;
    end
  end

  // Abort wins over everything: it suppresses this cycle's request, strobes and load.
  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    line_d       = line_q;
    size16_d     = size16_q;
    yflip_d      = yflip_q;
    xono_d       = xono_q;
    md_d         = md_q;
    vram_req_o   = 1'b0;
    latch_lo_o   = 1'b0;
    latch_hi_o   = 1'b0;
    load_mask_o  = '0;
    fetch_done_o = 1'b0;

    if (fetch_abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fetch_req_i) begin
            tile_d   = spr_tile_i;
            line_d   = spr_line_i;
            size16_d = obj_size16_i;
            yflip_d  = spr_attr_i[FLAG_YFLIP];
            xono_d   = spr_attr_i[FLAG_XFLIP];
            state_d  = ST_REQ_LO;
          end
        end
        ST_REQ_LO: begin
          vram_req_o = 1'b1;
          if (vram_ack_i) begin
            md_d    = vram_data_i;
            state_d = ST_CAP_LO;
          end
        end
        ST_CAP_LO: begin
          latch_lo_o = 1'b1;
          state_d    = ST_REQ_HI;
        end
        ST_REQ_HI: begin
          vram_req_o = 1'b1;
          if (vram_ack_i) begin
            md_d    = vram_data_i;
            state_d = ST_CAP_HI;
          end
        end
        ST_CAP_HI: begin
          latch_hi_o = 1'b1;
          state_d    = ST_LOAD;
        end
        ST_LOAD: begin
          load_mask_o  = ~pipe_occ_i;
          fetch_done_o = 1'b1;
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign vram_addr_o = (state_q == ST_REQ_LO || state_q == ST_REQ_HI) ? row_addr : '0;
  assign md_o        = md_q;
  assign xono_o      = xono_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Scoreboard bench for sprite_fetch_sequencer: a VRAM responder with random
// ack delay, an arithmetic address/mask model, and a monitor that pops expectations.
module tb_sprite_fetch_sequencer;
  import obj_pkg::*;

  typedef enum int {EV_ADDR, EV_LO, EV_HI, EV_DONE} evKind_t;
  typedef struct {
    evKind_t kind;
    int      value;
    int      xono;
  } expEv_t;

  logic              clk;
  logic              rstN;
  logic              fetchReq;
  logic              fetchAbort;
  logic [7:0]        sprTile;
  logic [7:0]        sprAttr;
  logic [3:0]        sprLine;
  logic              objSize16;
  logic [7:0]        pipeOcc;
  logic              vramReq;
  logic [ADDR_W-1:0] vramAddr;
  logic              vramAck;
  logic [7:0]        vramData;
  logic [7:0]        md;
  logic              xono;
  logic              latchLo;
  logic              latchHi;
  logic [7:0]        loadMask;
  logic              busy;
  logic              fetchDone;

  logic [7:0] vramMem [0:8191];
  expEv_t     expQ [$];
  int         checks;
  int         errors;
  int         ackDelay;
  bit         forceAck;

  sprite_fetch_sequencer dut (
    .clk_i         (clk),
    .rst_n_i       (rstN),
    .fetch_req_i   (fetchReq),
    .fetch_abort_i (fetchAbort),
    .spr_tile_i    (sprTile),
    .spr_attr_i    (sprAttr),
    .spr_line_i    (sprLine),
    .obj_size16_i  (objSize16),
    .pipe_occ_i    (pipeOcc),
    .vram_req_o    (vramReq),
    .vram_addr_o   (vramAddr),
    .vram_ack_i    (vramAck),
    .vram_data_i   (vramData),
    .md_o          (md),
    .xono_o        (xono),
    .latch_lo_o    (latchLo),
    .latch_hi_o    (latchHi),
    .load_mask_o   (loadMask),
    .busy_o        (busy),
    .fetch_done_o  (fetchDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteUnexpected(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL unexpected_%s: value 0x%0h with no matching expectation at %0t", name, actual, $time);
  endtask

  // Tiles are 16 bytes apart; a row is two bytes (low plane, then high plane).
  function automatic int modelAddr(input int tile, input int line, input int size16, input int yflip);
    int rows;
    int row;
    int t;
    rows = (size16 != 0) ? 16 : 8;
    row  = line % rows;
    if (yflip != 0) row = rows - 1 - row;
    t = (size16 != 0) ? (tile & 'hFE) : tile;
    return t * 16 + row * 2;
  endfunction

  function automatic logic [63:0] outVec();
    return 64'({vramReq, vramAddr, md, xono, latchLo, latchHi, loadMask, busy, fetchDone});
  endfunction

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic pushFetch(input int tile, input int attr, input int line, input int size16, input int occ);
    int lo;
    int xf;
    lo = modelAddr(tile, line, size16, (attr >> FLAG_YFLIP) & 1);
    xf = (attr >> FLAG_XFLIP) & 1;
    expQ.push_back('{EV_ADDR, lo, 0});
    expQ.push_back('{EV_LO, int'(vramMem[lo]), xf});
    expQ.push_back('{EV_ADDR, lo + 1, 0});
    expQ.push_back('{EV_HI, int'(vramMem[lo + 1]), 0});
    expQ.push_back('{EV_DONE, (~occ) & 'hFF, 0});
  endtask

  task automatic applyStimulus(input int tile, input int attr, input int line, input int size16,
                               input int occ, input int delay, input bit extraReq);
    int cyc;
    bit seen;
    pushFetch(tile, attr, line, size16, occ);
    waitNeg();
    sprTile   = 8'(tile);
    sprAttr   = 8'(attr);
    sprLine   = 4'(line);
    objSize16 = 1'(size16);
    pipeOcc   = 8'(occ);
    ackDelay  = delay;
    fetchReq  = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      seen = fetchDone;
      #1;
      fetchReq = extraReq && (cyc == 2);
      if (extraReq && cyc == 2) begin
        sprTile = 8'($urandom);
        sprAttr = 8'($urandom);
        sprLine = 4'($urandom);
      end
    end
    checkOutput("fetch_done_latency", seen ? 64'(cyc) : 64'hDEAD, 64'(5 + 2 * delay));
    fetchReq = 1'b0;
    waitNeg();
    checkOutput("busy_after_done", busy, 0);
    checkOutput("queue_drained", 64'(expQ.size()), 0);
  endtask

  // Abort lands in REQ_HI together with an ack.
  task automatic abortTest();
    int lo;
    lo = modelAddr('h21, 5, 0, 0);
    expQ.push_back('{EV_ADDR, lo, 0});
    expQ.push_back('{EV_LO, int'(vramMem[lo]), 0});
    expQ.push_back('{EV_ADDR, lo + 1, 0});
    waitNeg();
    sprTile = 8'h21; sprAttr = 8'h00; sprLine = 4'd5; objSize16 = 1'b0; pipeOcc = 8'h00;
    ackDelay = 0;
    fetchReq = 1'b1;
    waitNeg();
    fetchReq = 1'b0;
    waitNeg();
    waitNeg();
    fetchAbort = 1'b1;
    forceAck   = 1'b1;
    #2;
    checkOutput("abort_req_drop", vramReq, 0);
    checkOutput("abort_no_latch_hi", latchHi, 0);
    waitNeg();
    fetchAbort = 1'b0;
    forceAck   = 1'b0;
    checkOutput("abort_busy_clear", busy, 0);
    checkOutput("abort_md_hold", md, vramMem[lo]);
    waitNeg();
    checkOutput("abort_queue_left", 64'(expQ.size()), 1);
    expQ.delete();
    waitNeg();
  endtask

  task automatic resetMidFetch();
    pushFetch('h44, 'h00, 2, 0, 'h00);
    waitNeg();
    sprTile = 8'h44; sprAttr = 8'h00; sprLine = 4'd2; objSize16 = 1'b0; pipeOcc = 8'h00;
    ackDelay = 0;
    fetchReq = 1'b1;
    waitNeg();
    fetchReq = 1'b0;
    waitNeg();
    checkOutput("cap_lo_before_reset", latchLo, 1);
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_outputs", outVec(), 0);
    expQ.delete();
    forceAck = 1'b1;
    waitNeg();
    waitNeg();
    rstN = 1'b1;
    waitNeg();
    waitNeg();
    forceAck = 1'b0;
    checkOutput("idle_after_late_ack", outVec(), 0);
    waitNeg();
    checkOutput("still_idle", busy, 0);
  endtask

  // VRAM responder: acks after ackDelay waiting cycles, or at once when forced.
  initial begin
    int waitCnt;
    waitCnt  = 0;
    vramAck  = 1'b0;
    vramData = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (forceAck) begin
        vramAck  = 1'b1;
        vramData = vramMem[vramAddr];
        waitCnt  = 0;
      end else if (vramReq) begin
        if (waitCnt >= ackDelay) begin
          vramAck  = 1'b1;
          vramData = vramMem[vramAddr];
          waitCnt  = 0;
        end else begin
          vramAck = 1'b0;
          waitCnt++;
        end
      end else begin
        vramAck = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Monitor: address expectations are peeked while requesting and retired by the strobe.
  initial begin
    expEv_t e;
    bit prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prevDone = 1'b0;
        continue;
      end
      if (prevDone) checkOutput("load_mask_clear", loadMask, 0);
      prevDone = fetchDone;
      if (vramReq) begin
        if (expQ.size() > 0 && expQ[0].kind == EV_ADDR) checkOutput("vram_addr", vramAddr, 64'(expQ[0].value));
        else noteUnexpected("vram_req", vramAddr);
      end
      if (latchLo || latchHi) begin
        if (expQ.size() > 1 && expQ[0].kind == EV_ADDR && expQ[1].kind == (latchLo ? EV_LO : EV_HI)) begin
          void'(expQ.pop_front());
          e = expQ.pop_front();
          checkOutput(latchLo ? "md_lo" : "md_hi", md, 64'(e.value));
          if (latchLo) checkOutput("xono", xono, 64'(e.xono));
        end else begin
          noteUnexpected(latchLo ? "latch_lo" : "latch_hi", md);
        end
      end
      if (fetchDone) begin
        if (expQ.size() > 0 && expQ[0].kind == EV_DONE) begin
          e = expQ.pop_front();
          checkOutput("load_mask", loadMask, 64'(e.value));
        end else begin
          noteUnexpected("fetch_done", loadMask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    ackDelay   = 0;
    forceAck   = 1'b0;
    rstN       = 1'b0;
    fetchReq   = 1'b0;
    fetchAbort = 1'b0;
    sprTile    = '0;
    sprAttr    = '0;
    sprLine    = '0;
    objSize16  = 1'b0;
    pipeOcc    = '0;
    for (int i = 0; i < 8192; i++) vramMem[i] = 8'($urandom);
    vramMem['h126] = 8'hA5;
    vramMem['h127] = 8'h3C;
    #3;
    checkOutput("reset_outputs", outVec(), 0);
    waitNeg();
    waitNeg();
    rstN = 1'b1;
    waitNeg();
    checkOutput("idle_after_reset", busy, 0);

    applyStimulus('h12, 'h00, 3, 0, 'h00, 0, 1'b0);
    applyStimulus('h13, 'h60, 12, 1, 'h00, 0, 1'b0);
    applyStimulus('h12, 'h00, 3, 0, 'h00, 2, 1'b0);
    applyStimulus('h5A, 'h20, 7, 0, 'hF0, 1, 1'b0);
    applyStimulus('h80, 'h40, 0, 1, 'hFF, 0, 1'b1);
    applyStimulus('hFF, 'h40, 15, 1, 'h0F, 3, 1'b0);

    abortTest();
    waitNeg();
    applyStimulus('h21, 'h00, 5, 0, 'h3C, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    resetMidFetch();
    applyStimulus('h12, 'h00, 3, 0, 'h00, 0, 1'b0);

    waitNeg();
    waitNeg();
    checkOutput("final_queue_empty", 64'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
